ysyx_23060187_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit. It sits directly downstream of the main controller and consumes its mul, mulh, div, divu, rem and remu decode flags, together with the two register operands. It computes the result over multiple cycles using valid/ready handshakes, then returns the result and the destination-register tag to writeback. The single-cycle ALU handles all other instructions.

---
 rtl/ysyx_23060187_muldiv.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_23060187_muldiv.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060187_muldiv.sv
// ============================================================================
// Module   : ysyx_23060187_muldiv
// Purpose  : Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060187_muldiv #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mul,
  input  logic            mulh,
  input  logic            div,
  input  logic            divu,
  input  logic            rem,
  input  logic            remu,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [TAGW-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] rd_out
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   C_LAST   = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] C_INTMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_MULH = 3'd1,
    OP_DIV  = 3'd2,
    OP_DIVU = 3'd3,
    OP_REM  = 3'd4,
    OP_REMU = 3'd5
  } op_t;

  state_t            r_state, w_next;
  op_t               r_op, w_req_op;
  logic              r_sign1, r_sign2;
  logic [XLEN-1:0]   r_mag1, r_mag2;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem, r_quo;
  logic [XLEN-1:0]   r_result;
  logic [TAGW-1:0]   r_rd;

  logic              w_req_any, w_signed, w_sign1, w_sign2;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic              w_is_div, w_div_zero, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0]   w_fast_res;

  // Request decode: priority select, sign capture and magnitudes.
  always_comb begin
    w_req_any = mul | mulh | div | divu | rem | remu;
    w_req_op  = OP_REMU;
    if (mul)       w_req_op = OP_MUL;
    else if (mulh) w_req_op = OP_MULH;
    else if (div)  w_req_op = OP_DIV;
    else if (divu) w_req_op = OP_DIVU;
    else if (rem)  w_req_op = OP_REM;
    w_signed   = (w_req_op != OP_DIVU) && (w_req_op != OP_REMU);
    w_sign1    = w_signed & src1[XLEN-1];
    w_sign2    = w_signed & src2[XLEN-1];
    w_mag1     = w_sign1 ? -src1 : src1;
    w_mag2     = w_sign2 ? -src2 : src2;
    w_is_div   = (w_req_op != OP_MUL) && (w_req_op != OP_MULH);
    w_div_zero = (src2 == '0);
    w_ovf      = ((w_req_op == OP_DIV) || (w_req_op == OP_REM)) &&
                 (src1 == C_INTMIN) && (src2 == '1);
    w_fast     = w_is_div & (w_div_zero | w_ovf);
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = ((w_req_op == OP_DIV) || (w_req_op == OP_DIVU)) ? '1 : src1;
    else if (w_req_op == OP_DIV)
      w_fast_res = C_INTMIN;
  end

  assign w_accept = in_valid & (r_state == IDLE) & w_req_any;

  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_acc_next, w_prod_fix;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_next, w_quo_next, w_final;

  // One shift-add multiply step and one restoring divide step per cycle.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag1} : {(XLEN+1){1'b0}});
    w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    w_shift    = {r_rem, r_quo[XLEN-1]};
    w_ge       = (w_shift >= {1'b0, r_mag2});
    w_rem_next = w_ge ? (w_shift[XLEN-1:0] - r_mag2) : w_shift[XLEN-1:0];
    w_quo_next = {r_quo[XLEN-2:0], w_ge};
    w_prod_fix = (r_sign1 ^ r_sign2) ? -w_acc_next : w_acc_next;
    case (r_op)
      OP_MUL:  w_final = w_prod_fix[XLEN-1:0];
      OP_MULH: w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV:  w_final = (r_sign1 ^ r_sign2) ? -w_quo_next : w_quo_next;
      OP_DIVU: w_final = w_quo_next;
      OP_REM:  w_final = r_sign1 ? -w_rem_next : w_rem_next;
      default: w_final = w_rem_next;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = w_fast ? DONE : CALC;
        CALC:    if (r_cnt == C_LAST) w_next = DONE;
        DONE:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_mag1   <= '0;
      r_mag2   <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= w_req_op;
        r_sign1 <= w_sign1;
        r_sign2 <= w_sign2;
        r_mag1  <= w_mag1;
        r_mag2  <= w_mag2;
        r_rd    <= rd_in;
        r_cnt   <= '0;
        r_acc   <= {{XLEN{1'b0}}, w_mag2};
        r_rem   <= '0;
        r_quo   <= w_mag1;
        if (w_fast) r_result <= w_fast_res;
      end
      if (r_state == CALC) begin
        r_acc <= w_acc_next;
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == C_LAST) r_result <= w_final;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign rd_out    = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060187_muldiv.sv
// ============================================================================
// Module   : tb_ysyx_23060187_muldiv
// Purpose  : Directed self-checking bench for the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060187_muldiv;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        mul, mulh, div, divu, rem, remu;
  logic [31:0] src1, src2, result;
  logic [4:0]  rd_in, rd_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [4:0]  rd;
  } vec_t;

  ysyx_23060187_muldiv #(.XLEN(32), .TAGW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mul(mul), .mulh(mulh), .div(div), .divu(divu), .rem(rem), .remu(remu),
    .src1(src1), .src2(src2), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // flags order: {mul, mulh, div, divu, rem, remu}
  task automatic drive_req(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    {mul, mulh, div, divu, rem, remu} = f;
    src1 = a; src2 = b; rd_in = rd; in_valid = 1'b1;
  endtask

  task automatic clear_req;
    {mul, mulh, div, divu, rem, remu} = 6'b0;
    src1 = 32'hA5A5_5A5A; src2 = 32'h5A5A_A5A5; rd_in = 5'h1F; in_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo, output bit rdy_bad);
    drive_req(f, a, b, rd);
    @(posedge clk); #1;
    clear_req();
    lat = 0; rdy_bad = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (in_ready) rdy_bad = 1'b1;
    res = result; rdo = rd_out;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    clear_req();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({in_ready, out_valid, result, rd_out} !== {1'b1, 1'b0, 32'd0, 5'd0}) begin
      n_err++;
      $display("FAIL reset: got rdy=%b vld=%b res=%h rd=%h want 1 0 0 0",
               in_ready, out_valid, result, rd_out);
    end
  endtask

  task automatic test_mul;
    vec_t v[5];
    int lat; logic [31:0] res; logic [4:0] rdo; bit bad;
    v[0] = '{6'b100000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd3};
    v[1] = '{6'b010000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd4};
    v[2] = '{6'b010000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5'd5};
    v[3] = '{6'b101001, 32'd6,         32'd7,         32'd42,        5'd6};
    v[4] = '{6'b010000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 5'd7};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, v[i].rd, lat, res, rdo, bad);
      n_vec++;
      if (res !== v[i].exp) begin
        n_err++; $display("FAIL mul[%0d] result: got %h want %h", i, res, v[i].exp);
      end
      n_vec++;
      if (lat !== 32) begin
        n_err++; $display("FAIL mul[%0d] latency: got %0d want 32", i, lat);
      end
      n_vec++;
      if ({rdo, bad} !== {v[i].rd, 1'b0}) begin
        n_err++; $display("FAIL mul[%0d] tag/in_ready: got rd=%h rdy_bad=%b want rd=%h 0",
                          i, rdo, bad, v[i].rd);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_div;
    vec_t v[8];
    int lat; logic [31:0] res; logic [4:0] rdo; bit bad;
    v[0] = '{6'b001000, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'd10};
    v[1] = '{6'b000010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'd11};
    v[2] = '{6'b000100, 32'd100,       32'd7,         32'd14,        5'd12};
    v[3] = '{6'b000001, 32'd100,       32'd7,         32'd2,         5'd13};
    v[4] = '{6'b001000, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd14};
    v[5] = '{6'b000010, 32'd7,         32'hFFFF_FFFE, 32'd1,         5'd15};
    v[6] = '{6'b000100, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 5'd16};
    v[7] = '{6'b000001, 32'hFFFF_FFFF, 32'd16,        32'd15,        5'd17};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, v[i].rd, lat, res, rdo, bad);
      n_vec++;
      if (res !== v[i].exp) begin
        n_err++; $display("FAIL div[%0d] result: got %h want %h", i, res, v[i].exp);
      end
      n_vec++;
      if ({rdo, bad, lat} !== {v[i].rd, 1'b0, 32'd32}) begin
        n_err++; $display("FAIL div[%0d] tag/lat: got rd=%h rdy_bad=%b lat=%0d want rd=%h 0 32",
                          i, rdo, bad, lat, v[i].rd);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_fast;
    vec_t v[6];
    int lat; logic [31:0] res; logic [4:0] rdo; bit bad;
    v[0] = '{6'b000100, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd20};
    v[1] = '{6'b000001, 32'd5,         32'd0,         32'd5,         5'd21};
    v[2] = '{6'b001000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd22};
    v[3] = '{6'b000010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd23};
    v[4] = '{6'b001000, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd24};
    v[5] = '{6'b000010, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 5'd25};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, v[i].rd, lat, res, rdo, bad);
      n_vec++;
      if (res !== v[i].exp) begin
        n_err++; $display("FAIL fast[%0d] result: got %h want %h", i, res, v[i].exp);
      end
      n_vec++;
      if ({rdo, bad, lat} !== {v[i].rd, 1'b0, 32'd0}) begin
        n_err++; $display("FAIL fast[%0d] tag/lat: got rd=%h rdy_bad=%b lat=%0d want rd=%h 0 0",
                          i, rdo, bad, lat, v[i].rd);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] res; logic [4:0] rdo; bit bad;
    out_ready = 1'b0;
    run_op(6'b000100, 32'd100, 32'd7, 5'd12, lat, res, rdo, bad);
    n_vec++;
    if ({res, lat} !== {32'd14, 32'd32}) begin
      n_err++; $display("FAIL bp first: got res=%h lat=%0d want 0000000e 32", res, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++;
      if ({out_valid, in_ready, result, rd_out} !== {1'b1, 1'b0, 32'd14, 5'd12}) begin
        n_err++; $display("FAIL bp hold[%0d]: got vld=%b rdy=%b res=%h rd=%h want 1 0 0000000e 0c",
                          i, out_valid, in_ready, result, rd_out);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    drive_req(6'b100000, 32'd3, 32'd5, 5'd2);
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp reaccept: got in_ready=%b want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    n_vec++;
    if ({result, rd_out, lat} !== {32'd15, 5'd2, 32'd32}) begin
      n_err++; $display("FAIL bp second op: got res=%h rd=%h lat=%0d want 0000000f 02 32",
                        result, rd_out, lat);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_abort;
    int lat; logic [31:0] res; logic [4:0] rdo; bit bad; bit seen;
    drive_req(6'b100000, 32'd7, 32'd9, 5'd8);
    @(posedge clk); #1;
    clear_req();
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL flush: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL flush no result: got out_valid seen=%b want 0", seen);
    end
    out_ready = 1'b0;
    run_op(6'b000100, 32'd5, 32'd0, 5'd9, lat, res, rdo, bad);
    n_vec++;
    if ({res, rdo, lat} !== {32'hFFFF_FFFF, 5'd9, 32'd0}) begin
      n_err++; $display("FAIL pre-rst op: got res=%h rd=%h lat=%0d want ffffffff 09 0", res, rdo, lat);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({out_valid, in_ready, result, rd_out} !== {1'b0, 1'b1, 32'd0, 5'd0}) begin
      n_err++; $display("FAIL rst in DONE: got vld=%b rdy=%b res=%h rd=%h want 0 1 0 0",
                        out_valid, in_ready, result, rd_out);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_noflag;
    drive_req(6'b000000, 32'd12, 32'd3, 5'd30);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_err++; $display("FAIL noflag[%0d]: got rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
      end
    end
    clear_req();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast();
    test_backpressure();
    test_abort();
    test_noflag();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
